// File: rtl/mem_access_master_pkg.sv
// Shared widths and FSM encodings for the memory access master.
// Benches import this package to probe state.
package mem_access_master_pkg;

  localparam int MEM_ADDR_WIDTH = 8;
  localparam int MEM_WORD_WIDTH = 16;

  typedef enum logic [2:0] {
    MAU_ST_IDLE   = 3'd0,
    MAU_ST_SETUP  = 3'd1,
    MAU_ST_STROBE = 3'd2,
    MAU_ST_CHECK  = 3'd3,
    MAU_ST_GAP    = 3'd4,
    MAU_ST_RESP   = 3'd5
  } mau_state_e;

  function automatic logic mau_strobe_on(input mau_state_e s);
    return (s == MAU_ST_STROBE) || (s == MAU_ST_CHECK);
  endfunction

  function automatic logic mau_cmd_on(input mau_state_e s);
    return (s == MAU_ST_SETUP) || (s == MAU_ST_STROBE) ||
           (s == MAU_ST_CHECK) || (s == MAU_ST_GAP);
  endfunction

endpackage

// File: rtl/mem_access_master.sv
// Load/store initiator for the math co-processor memory unit.
// Sets up command levels, strobes Mem_op_enable, retries stalls.
module mem_access_master
  import mem_access_master_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned RETRY_GAP = 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Req_valid,
  output logic                      Req_ready,
  input  logic                      Req_write,
  input  logic [MEM_ADDR_WIDTH-1:0] Req_addr,
  input  logic [MEM_WORD_WIDTH-1:0] Req_data,
  output logic                      Resp_valid,
  output logic [MEM_WORD_WIDTH-1:0] Resp_data,
  output logic                      Resp_error,
  output logic                      Read_sig,
  output logic                      Write_sig,
  output logic                      Mem_op_enable,
  output logic [MEM_ADDR_WIDTH-1:0] Address_out,
  output logic [MEM_WORD_WIDTH-1:0] Data_out,
  input  logic [MEM_WORD_WIDTH-1:0] Data_in,
  input  logic                      Mem_op_success
);

  localparam int RC = $clog2(MAX_RETRY + 1);
  localparam int RW = (RC < 1) ? 1 : RC;
  localparam int GC = $clog2(RETRY_GAP + 1);
  localparam int GW = (GC < 1) ? 1 : GC;
  localparam logic [RW-1:0] RMAX  = RW'(MAX_RETRY);
  localparam logic [GW-1:0] GLAST =
    (RETRY_GAP > 1) ? GW'(RETRY_GAP - 1) : '0;

  mau_state_e state_q, state_n;

  logic                      write_q, write_n;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [MEM_WORD_WIDTH-1:0] wdata_q, wdata_n;
  logic [RW-1:0]             retry_q, retry_n;
  logic [GW-1:0]             gap_q, gap_n;
  logic                      err_n;
  logic [MEM_WORD_WIDTH-1:0] rdata_n;

  logic                      ready_d, rvalid_d, rerr_d;
  logic                      rd_d, wr_d, en_d;
  logic [MEM_WORD_WIDTH-1:0] rdata_d, dout_d;
  logic [MEM_ADDR_WIDTH-1:0] aout_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= MAU_ST_IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      retry_q       <= '0;
      gap_q         <= '0;
      Req_ready     <= 1'b0;
      Resp_valid    <= 1'b0;
      Resp_data     <= '0;
      Resp_error    <= 1'b0;
      Read_sig      <= 1'b0;
      Write_sig     <= 1'b0;
      Mem_op_enable <= 1'b0;
      Address_out   <= '0;
      Data_out      <= '0;
    end else begin
      state_q       <= state_n;
      write_q       <= write_n;
      addr_q        <= addr_n;
      wdata_q       <= wdata_n;
      retry_q       <= retry_n;
      gap_q         <= gap_n;
      Req_ready     <= ready_d;
      Resp_valid    <= rvalid_d;
      Resp_data     <= rdata_d;
      Resp_error    <= rerr_d;
      Read_sig      <= rd_d;
      Write_sig     <= wr_d;
      Mem_op_enable <= en_d;
      Address_out   <= aout_d;
      Data_out      <= dout_d;
    end
  end

  always_comb begin
    state_n = state_q;
    write_n = write_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    retry_n = retry_q;
    gap_n   = gap_q;
    err_n   = 1'b0;
    rdata_n = '0;
    unique case (state_q)
      MAU_ST_IDLE: begin
        if (Req_valid && Req_ready) begin
          write_n = Req_write;
          addr_n  = Req_addr;
          wdata_n = Req_data;
          retry_n = '0;
          state_n = MAU_ST_SETUP;
        end
      end
      MAU_ST_SETUP:  state_n = MAU_ST_STROBE;
      MAU_ST_STROBE: state_n = MAU_ST_CHECK;
      MAU_ST_CHECK: begin
        if (Mem_op_success) begin
          if (!write_q) rdata_n = Data_in;
          state_n = MAU_ST_RESP;
        end else if (retry_q < RMAX) begin
          // saturating even if RW leaves headroom above MAX_RETRY
          retry_n = (retry_q == '1) ? retry_q : retry_q + 1'b1;
          gap_n   = '0;
          state_n = MAU_ST_GAP;
        end else begin
          err_n   = 1'b1;
          state_n = MAU_ST_RESP;
        end
      end
      MAU_ST_GAP: begin
        if (gap_q == GLAST) state_n = MAU_ST_STROBE;
        else                gap_n   = gap_q + 1'b1;
      end
      MAU_ST_RESP: state_n = MAU_ST_IDLE;
      default:     state_n = MAU_ST_IDLE;
    endcase
  end

  // outputs are registered, so they decode the next state
  always_comb begin
    ready_d  = (state_n == MAU_ST_IDLE);
    rvalid_d = (state_n == MAU_ST_RESP);
    rdata_d  = rdata_n;
    rerr_d   = err_n;
    rd_d     = mau_cmd_on(state_n) && !write_n;
    wr_d     = mau_cmd_on(state_n) && write_n;
    en_d     = mau_strobe_on(state_n);
    aout_d   = Address_out;
    dout_d   = Data_out;
    if (mau_cmd_on(state_n)) begin
      aout_d = addr_n;
      dout_d = wdata_n;
    end
  end

endmodule

// File: tb/tb_mem_access_master.sv
// Scoreboard bench for mem_access_master with a behavioural
// memory unit that stalls a scripted number of attempts.
module tb_mem_access_master;
  import mem_access_master_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req_valid = 1'b0;
  logic        Req_ready;
  logic        Req_write = 1'b0;
  logic [7:0]  Req_addr = '0;
  logic [15:0] Req_data = '0;
  logic        Resp_valid;
  logic [15:0] Resp_data;
  logic        Resp_error;
  logic        Read_sig;
  logic        Write_sig;
  logic        Mem_op_enable;
  logic [7:0]  Address_out;
  logic [15:0] Data_out;
  logic [15:0] Data_in = '0;
  logic        Mem_op_success = 1'b0;

  mem_access_master #(.MAX_RETRY(3), .RETRY_GAP(1)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req_valid(Req_valid), .Req_ready(Req_ready),
    .Req_write(Req_write), .Req_addr(Req_addr),
    .Req_data(Req_data),
    .Resp_valid(Resp_valid), .Resp_data(Resp_data),
    .Resp_error(Resp_error),
    .Read_sig(Read_sig), .Write_sig(Write_sig),
    .Mem_op_enable(Mem_op_enable),
    .Address_out(Address_out), .Data_out(Data_out),
    .Data_in(Data_in), .Mem_op_success(Mem_op_success)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          acc;
    int          lat;
    int          pulses;
    int          pbase;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tot_pulses = 0;
  int cur_acc = 0;
  int cur_pbase = 0;
  int stall_cfg = 0;
  int last_acc = 0;
  logic        cur_w = 1'b0;
  logic [7:0]  cur_a = '0;
  logic [15:0] cur_d = '0;
  logic        abort = 1'b0;
  logic        started = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  // memory model plus response/protocol monitor
  logic [15:0] mem [0:255];
  bit          loaded = 0;
  logic        prev_en = 1'b0;
  int          hi_cnt = 0;
  logic        s_rd, s_wr;
  logic [7:0]  s_a;
  logic [15:0] s_d;

  always @(negedge Clk) begin
    exp_t e;
    int   att;
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h0F] = 16'hF00F;
      loaded = 1;
    end
    if (started && Mem_op_enable === 1'b1 && prev_en !== 1'b1) begin
      tot_pulses++;
      att = tot_pulses - cur_pbase;
      checks++;
      if (Address_out !== cur_a || Write_sig !== cur_w ||
          Read_sig !== !cur_w || (cur_w && Data_out !== cur_d)) begin
        failures++;
        $display("FAIL cmd_setup got a=%h w=%b r=%b d=%h need a=%h w=%b d=%h",
                 Address_out, Write_sig, Read_sig, Data_out,
                 cur_a, cur_w, cur_d);
      end
      if (att == 1) begin
        checks++;
        if (cyc - cur_acc + 1 != 2) begin
          failures++;
          $display("FAIL enable_rise got T+%0d need T+2",
                   cyc - cur_acc + 1);
        end
      end
      if (att <= stall_cfg) begin
        Mem_op_success = 1'b0;
        Data_in = 16'h5A5A;
      end else begin
        Mem_op_success = 1'b1;
        if (Write_sig) begin
          mem[Address_out] = Data_out;
          Data_in = 16'hA5A5;
        end else begin
          Data_in = mem[Address_out];
        end
      end
    end
    if (started) begin
      checks++;
      if (Read_sig === 1'b1 && Write_sig === 1'b1) begin
        failures++;
        $display("FAIL rw_exclusive got r=1 w=1 need not both");
      end
      if (Mem_op_enable === 1'b1 && prev_en === 1'b1) begin
        checks++;
        if (Read_sig !== s_rd || Write_sig !== s_wr ||
            Address_out !== s_a || Data_out !== s_d) begin
          failures++;
          $display("FAIL cmd_stable got a=%h need a=%h", Address_out, s_a);
        end
      end
      if (Mem_op_enable === 1'b1) hi_cnt++;
      if (Mem_op_enable !== 1'b1 && prev_en === 1'b1) begin
        if (!abort) begin
          checks++;
          if (hi_cnt != 2) begin
            failures++;
            $display("FAIL pulse_width got %0d need 2", hi_cnt);
          end
        end
        hi_cnt = 0;
      end
      if (Resp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp got data=%h need none", Resp_data);
        end else begin
          e = sb.pop_front();
          checks++;
          if (Resp_data !== e.data || Resp_error !== e.err) begin
            failures++;
            $display("FAIL resp got data=%h err=%b need data=%h err=%b",
                     Resp_data, Resp_error, e.data, e.err);
          end
          checks++;
          if (cyc - e.acc + 1 != e.lat) begin
            failures++;
            $display("FAIL latency got %0d need %0d",
                     cyc - e.acc + 1, e.lat);
          end
          checks++;
          if (tot_pulses - e.pbase != e.pulses) begin
            failures++;
            $display("FAIL pulses got %0d need %0d",
                     tot_pulses - e.pbase, e.pulses);
          end
        end
      end
    end
    prev_en = Mem_op_enable;
    s_rd = Read_sig;
    s_wr = Write_sig;
    s_a  = Address_out;
    s_d  = Data_out;
  end

  task automatic issue(
    input logic w, input logic [7:0] a, input logic [15:0] d,
    input int stalls, input logic [15:0] ed, input logic ee,
    input int elat, input int ep, input bit keep, input int gap
  );
    int   n;
    exp_t e;
    Req_valid = 1'b1;
    Req_write = w;
    Req_addr  = a;
    Req_data  = d;
    n = 0;
    while (Req_ready !== 1'b1 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (Req_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got ready=%b need 1", Req_ready);
      Req_valid = 1'b0;
      return;
    end
    cur_w     = w;
    cur_a     = a;
    cur_d     = d;
    cur_acc   = cyc + 1;
    cur_pbase = tot_pulses;
    stall_cfg = stalls;
    if (gap > 0) begin
      checks++;
      if (cur_acc - last_acc != gap) begin
        failures++;
        $display("FAIL accept_gap got %0d need %0d",
                 cur_acc - last_acc, gap);
      end
    end
    last_acc = cur_acc;
    e.data = ed; e.err = ee; e.acc = cur_acc;
    e.lat = elat; e.pulses = ep; e.pbase = tot_pulses;
    sb.push_back(e);
    @(negedge Clk);
    if (!keep) Req_valid = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] need);
    checks++;
    if (got !== need) begin
      failures++;
      $display("FAIL %s got %h need %h", nm, got, need);
    end
  endtask

  initial begin
    int n;
    repeat (2) @(negedge Clk);
    chk("reset_ready", {15'd0, Req_ready}, 16'd0);
    chk("reset_en", {15'd0, Mem_op_enable}, 16'd0);
    chk("reset_rw", {14'd0, Read_sig, Write_sig}, 16'd0);
    chk("reset_resp", {15'd0, Resp_valid}, 16'd0);
    Reset = 1'b0;
    started = 1'b1;
    @(negedge Clk);
    chk("ready_after_reset", {15'd0, Req_ready}, 16'd1);

    issue(1'b0, 8'h0F, 16'h0000, 0,  16'hF00F, 1'b0, 4,  1, 0, 0);
    issue(1'b1, 8'h03, 16'h1234, 0,  16'h0000, 1'b0, 4,  1, 0, 0);
    issue(1'b0, 8'h03, 16'h0000, 0,  16'h1234, 1'b0, 4,  1, 0, 0);
    issue(1'b0, 8'h0F, 16'h0000, 2,  16'hF00F, 1'b0, 10, 3, 0, 0);
    issue(1'b1, 8'h03, 16'hDEAD, 99, 16'h0000, 1'b1, 13, 4, 0, 0);
    issue(1'b0, 8'h03, 16'h0000, 0,  16'h1234, 1'b0, 4,  1, 0, 0);
    issue(1'b0, 8'h0F, 16'h0000, 99, 16'h0000, 1'b1, 13, 4, 0, 0);
    issue(1'b1, 8'h05, 16'hBEEF, 1,  16'h0000, 1'b0, 7,  2, 0, 0);

    // abort an in-flight load while the strobe is high
    n = 0;
    while (Req_ready !== 1'b1 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    Req_valid = 1'b1;
    Req_write = 1'b0;
    Req_addr  = 8'h0F;
    cur_w = 1'b0; cur_a = 8'h0F; cur_acc = cyc + 1;
    cur_pbase = tot_pulses; stall_cfg = 99;
    @(negedge Clk);
    Req_valid = 1'b0;
    n = 0;
    while (Mem_op_enable !== 1'b1 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("abort_reach_strobe", {15'd0, Mem_op_enable}, 16'd1);
    abort = 1'b1;
    Reset = 1'b1;
    @(negedge Clk);
    chk("abort_en", {15'd0, Mem_op_enable}, 16'd0);
    chk("abort_rw", {14'd0, Read_sig, Write_sig}, 16'd0);
    chk("abort_resp", {15'd0, Resp_valid}, 16'd0);
    chk("abort_ready", {15'd0, Req_ready}, 16'd0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("abort_ready_after", {15'd0, Req_ready}, 16'd1);
    abort = 1'b0;

    issue(1'b0, 8'h05, 16'h0000, 0, 16'hBEEF, 1'b0, 4, 1, 1, 0);
    issue(1'b0, 8'h0F, 16'h0000, 0, 16'hF00F, 1'b0, 4, 1, 1, 5);
    issue(1'b1, 8'h07, 16'h7777, 0, 16'h0000, 1'b0, 4, 1, 0, 5);
    issue(1'b0, 8'h07, 16'h0000, 0, 16'h7777, 1'b0, 4, 1, 0, 0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got %0d pending need 0", sb.size());
    end
    repeat (3) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
